// File: rtl/final2_soc_nios2_oci_pkg.sv
// rtl/final2_soc_nios2_oci_pkg.sv - shared constants, state enum and helpers for the OCI DCT packer
package final2_soc_nios2_oci_pkg;

    localparam int CODE_W = 2;
    localparam int DEPTH  = 15;
    localparam int BUF_W  = CODE_W * DEPTH;
    localparam int CNT_W  = 4;

    localparam logic [CODE_W-1:0] CODE_NOP = 2'b00;
    localparam logic [CNT_W-1:0]  FULL_CNT = CNT_W'(DEPTH);

    typedef enum logic [1:0] {
        ST_EMPTY     = 2'd0,
        ST_FILL      = 2'd1,
        ST_FULL_WAIT = 2'd2
    } dct_state_e;

    // Place a code into the slot addressed by idx (slot 0 is the oldest, bits [1:0])
    function automatic logic [BUF_W-1:0] place_code(input logic [CODE_W-1:0] c,
                                                    input logic [CNT_W-1:0]  idx);
        logic [BUF_W-1:0] v;
        v = {{(BUF_W-CODE_W){1'b0}}, c};
        return v << (CODE_W * int'(idx));
    endfunction

endpackage

// File: rtl/final2_soc_nios2_qsys_0_oci_dct_packer_if.sv
// rtl/final2_soc_nios2_qsys_0_oci_dct_packer_if.sv - code input and frame output handshake bundle
interface final2_soc_nios2_qsys_0_oci_dct_packer_if;
    import final2_soc_nios2_oci_pkg::*;

    logic              code_valid;
    logic [CODE_W-1:0] code;
    logic              frame_valid;
    logic              frame_ready;
    logic [BUF_W-1:0]  dct_buffer;
    logic [CNT_W-1:0]  dct_count;

    // Trace source and frame consumer side
    modport master (
        output code_valid,
        output code,
        output frame_ready,
        input  frame_valid,
        input  dct_buffer,
        input  dct_count
    );

    // Packer side
    modport slave (
        input  code_valid,
        input  code,
        input  frame_ready,
        output frame_valid,
        output dct_buffer,
        output dct_count
    );
endinterface

// File: rtl/final2_soc_nios2_qsys_0_oci_dct_frame_reg.sv
// rtl/final2_soc_nios2_qsys_0_oci_dct_frame_reg.sv - single-entry valid/ready frame holding register
module final2_soc_nios2_qsys_0_oci_dct_frame_reg
    import final2_soc_nios2_oci_pkg::*;
(
    input  logic             clk,
    input  logic             reset_n,
    input  logic             load,
    input  logic [BUF_W-1:0] load_buffer,
    input  logic [CNT_W-1:0] load_count,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BUF_W-1:0] out_buffer,
    output logic [CNT_W-1:0] out_count
);

    logic             valid_q, valid_d;
    logic [BUF_W-1:0] buffer_q, buffer_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Load wins over a same-cycle handshake so back-to-back frames have no bubble
    always_comb begin
        valid_d  = valid_q;
        buffer_d = buffer_q;
        count_d  = count_q;
        if (load) begin
            valid_d  = 1'b1;
            buffer_d = load_buffer;
            count_d  = load_count;
        end else if (out_ready) begin
            valid_d  = 1'b0;
        end
    end

    // Holding register state
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            valid_q  <= 1'b0;
            buffer_q <= '0;
            count_q  <= '0;
        end else begin
            valid_q  <= valid_d;
            buffer_q <= buffer_d;
            count_q  <= count_d;
        end
    end

    assign out_valid  = valid_q;
    assign out_buffer = buffer_q;
    assign out_count  = count_q;

endmodule

// File: rtl/final2_soc_nios2_qsys_0_oci_dct_packer.sv
// rtl/final2_soc_nios2_qsys_0_oci_dct_packer.sv - DCT code packer, optional FINAL2_SOC_DCT_DROP_CNT_EN drop counter
module final2_soc_nios2_qsys_0_oci_dct_packer
    import final2_soc_nios2_oci_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        flush,
    final2_soc_nios2_qsys_0_oci_dct_packer_if.slave dct_if,
    output logic        overflow,
`ifdef FINAL2_SOC_DCT_DROP_CNT_EN
    output logic [15:0] drop_cnt,
`endif
    output logic        drained
);

    dct_state_e       state_q, state_d;
    logic [BUF_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
    logic             overflow_q, overflow_d;
    logic             drained_q, drained_d;
    logic             drain_pend_q, drain_pend_d;

    logic             code_req;
    logic             store;
    logic             dropped;
    logic [CNT_W-1:0] cnt_inc;
    logic [BUF_W-1:0] acc_merged;
    logic             slot_free;
    logic             xfer;
    logic             frame_valid_next;
    logic             drain_arm;

    // Accept decision and the accumulator image including this cycle's code
    always_comb begin
        code_req   = dct_if.code_valid && (dct_if.code != CODE_NOP);
        store      = code_req && (state_q != ST_FULL_WAIT);
        dropped    = code_req && (state_q == ST_FULL_WAIT);
        cnt_inc    = acc_cnt_q + {{(CNT_W-1){1'b0}}, store};
        acc_merged = store ? (acc_q | place_code(dct_if.code, acc_cnt_q)) : acc_q;
        slot_free  = !dct_if.frame_valid || dct_if.frame_ready;
        xfer       = slot_free && ((cnt_inc == FULL_CNT) || (flush && (cnt_inc != '0)));
        frame_valid_next = xfer || (dct_if.frame_valid && !dct_if.frame_ready);
    end

    // Next-state for the fill FSM and accumulator
    always_comb begin
        state_d   = state_q;
        acc_d     = acc_merged;
        acc_cnt_d = cnt_inc;
        if (xfer) begin
            state_d   = ST_EMPTY;
            acc_d     = '0;
            acc_cnt_d = '0;
        end else if (cnt_inc == '0) begin
            state_d   = ST_EMPTY;
        end else if (cnt_inc == FULL_CNT) begin
            state_d   = ST_FULL_WAIT;
        end else begin
            state_d   = ST_FILL;
        end
    end

    // Sticky overflow and flush-drain tracking; a new code cancels a pending drain
    always_comb begin
        overflow_d   = overflow_q | dropped;
        drain_arm    = drain_pend_q || flush;
        drain_pend_d = drain_pend_q;
        drained_d    = drained_q;
        if (store && !flush) begin
            drain_pend_d = 1'b0;
            drained_d    = 1'b0;
        end else if (drain_arm && (acc_cnt_d == '0) && !frame_valid_next) begin
            drain_pend_d = 1'b0;
            drained_d    = 1'b1;
        end else if (drain_arm) begin
            drain_pend_d = 1'b1;
        end
    end

    // Packer state registers
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_EMPTY;
            acc_q        <= '0;
            acc_cnt_q    <= '0;
            overflow_q   <= 1'b0;
            drained_q    <= 1'b0;
            drain_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            acc_cnt_q    <= acc_cnt_d;
            overflow_q   <= overflow_d;
            drained_q    <= drained_d;
            drain_pend_q <= drain_pend_d;
        end
    end

`ifdef FINAL2_SOC_DCT_DROP_CNT_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    // Saturating count of dropped codes
    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (dropped && (drop_cnt_q != 16'hFFFF)) begin
            drop_cnt_d = drop_cnt_q + 16'd1;
        end
    end

    // Drop counter register
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
        end else begin
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign drop_cnt = drop_cnt_q;
`endif

    final2_soc_nios2_qsys_0_oci_dct_frame_reg u_frame_reg (
        .clk         (clk),
        .reset_n     (reset_n),
        .load        (xfer),
        .load_buffer (acc_merged),
        .load_count  (cnt_inc),
        .out_ready   (dct_if.frame_ready),
        .out_valid   (dct_if.frame_valid),
        .out_buffer  (dct_if.dct_buffer),
        .out_count   (dct_if.dct_count)
    );

    assign overflow = overflow_q;
    assign drained  = drained_q;

endmodule

// File: tb/tb_final2_soc_nios2_qsys_0_oci_dct_packer.sv
// tb/tb_final2_soc_nios2_qsys_0_oci_dct_packer.sv - directed self-checking bench for the DCT packer
module tb_final2_soc_nios2_qsys_0_oci_dct_packer;
    import final2_soc_nios2_oci_pkg::*;

    logic clk = 1'b0;
    logic reset_n;
    logic flush;
    logic overflow;
    logic drained;
`ifdef FINAL2_SOC_DCT_DROP_CNT_EN
    logic [15:0] drop_cnt;
`endif

    int total = 0;
    int bad   = 0;

    final2_soc_nios2_qsys_0_oci_dct_packer_if u_if ();

    final2_soc_nios2_qsys_0_oci_dct_packer dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .flush    (flush),
        .dct_if   (u_if),
        .overflow (overflow),
`ifdef FINAL2_SOC_DCT_DROP_CNT_EN
        .drop_cnt (drop_cnt),
`endif
        .drained  (drained)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b0;
        flush = 1'b0;
        u_if.code_valid = 1'b0;
        u_if.code = 2'b00;
        u_if.frame_ready = 1'b0;
        tick();
        tick();
        check_eq("rst_fv",  32'(u_if.frame_valid), 32'd0);
        check_eq("rst_buf", 32'(u_if.dct_buffer),  32'd0);
        check_eq("rst_cnt", 32'(u_if.dct_count),   32'd0);
        check_eq("rst_ovf", 32'(overflow),         32'd0);
        check_eq("rst_drn", 32'(drained),          32'd0);
        reset_n = 1'b1;

        // 15 codes of 01 with ready high
        u_if.frame_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            u_if.code_valid = 1'b1;
            u_if.code = 2'b01;
            tick();
            if (i < 14) check_eq("full_early_fv", 32'(u_if.frame_valid), 32'd0);
        end
        u_if.code_valid = 1'b0;
        check_eq("full_fv",  32'(u_if.frame_valid), 32'd1);
        check_eq("full_buf", 32'(u_if.dct_buffer),  32'h15555555);
        check_eq("full_cnt", 32'(u_if.dct_count),   32'd15);
        tick();
        check_eq("full_consumed", 32'(u_if.frame_valid), 32'd0);

        // 3,2,1 then flush
        u_if.code_valid = 1'b1;
        u_if.code = 2'd3; tick();
        u_if.code = 2'd2; tick();
        u_if.code = 2'd1; tick();
        u_if.code_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_fv",  32'(u_if.frame_valid), 32'd1);
        check_eq("flush_cnt", 32'(u_if.dct_count),   32'd3);
        check_eq("flush_buf", 32'(u_if.dct_buffer),  32'h0000001B);
        check_eq("flush_drn_early", 32'(drained),    32'd0);
        tick();
        check_eq("flush_drained", 32'(drained),          32'd1);
        check_eq("flush_fv_done", 32'(u_if.frame_valid), 32'd0);

        // NOPs interleaved: 1,0,2,0,0,3,1 -> 4 codes
        begin
            logic [1:0] seq [7];
            seq = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd3, 2'd1};
            for (int i = 0; i < 7; i++) begin
                u_if.code_valid = 1'b1;
                u_if.code = seq[i];
                tick();
                if (i == 0) check_eq("nop_drn_clr", 32'(drained), 32'd0);
            end
        end
        u_if.code_valid = 1'b0;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("nop_cnt", 32'(u_if.dct_count),  32'd4);
        check_eq("nop_buf", 32'(u_if.dct_buffer), 32'h00000079);
        tick();
        check_eq("nop_drained", 32'(drained), 32'd1);

        // ready low, 31 codes: 15 x 2, 15 x 3, then a 1 that must drop
        u_if.frame_ready = 1'b0;
        for (int i = 0; i < 31; i++) begin
            u_if.code_valid = 1'b1;
            u_if.code = (i < 15) ? 2'd2 : ((i < 30) ? 2'd3 : 2'd1);
            tick();
            if (i == 14) check_eq("ovf_first_fv", 32'(u_if.frame_valid), 32'd1);
            if (i == 29) check_eq("ovf_before", 32'(overflow), 32'd0);
        end
        u_if.code_valid = 1'b0;
        check_eq("ovf_set",    32'(overflow),         32'd1);
        check_eq("ovf_hold_b", 32'(u_if.dct_buffer), 32'h2AAAAAAA);
        check_eq("ovf_hold_c", 32'(u_if.dct_count),  32'd15);
`ifdef FINAL2_SOC_DCT_DROP_CNT_EN
        check_eq("ovf_drop_cnt", 32'(drop_cnt), 32'd1);
`endif

        // release: FULL_WAIT accumulator follows with no bubble
        u_if.frame_ready = 1'b1;
        tick();
        check_eq("b2b_fw_fv",  32'(u_if.frame_valid), 32'd1);
        check_eq("b2b_fw_buf", 32'(u_if.dct_buffer),  32'h3FFFFFFF);

        // held frame, ready arrives with the 15th code of the next frame
        for (int i = 0; i < 15; i++) begin
            u_if.frame_ready = (i == 14);
            u_if.code_valid = 1'b1;
            u_if.code = 2'b01;
            tick();
            if (i == 13) check_eq("b2b_held", 32'(u_if.dct_buffer), 32'h3FFFFFFF);
        end
        u_if.code_valid = 1'b0;
        check_eq("b2b_fv",  32'(u_if.frame_valid), 32'd1);
        check_eq("b2b_buf", 32'(u_if.dct_buffer),  32'h15555555);
        check_eq("b2b_cnt", 32'(u_if.dct_count),   32'd15);
`ifdef FINAL2_SOC_DCT_DROP_CNT_EN
        check_eq("b2b_no_drop", 32'(drop_cnt), 32'd1);
`endif
        u_if.frame_ready = 1'b1;
        tick();
        check_eq("b2b_done", 32'(u_if.frame_valid), 32'd0);

        // reset with held frame and partial accumulator
        u_if.frame_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            u_if.code_valid = 1'b1;
            u_if.code = (i < 15) ? 2'd1 : 2'd2;
            tick();
        end
        u_if.code_valid = 1'b0;
        check_eq("mid_fv", 32'(u_if.frame_valid), 32'd1);
        reset_n = 1'b0;
        tick();
        check_eq("mr_fv",  32'(u_if.frame_valid), 32'd0);
        check_eq("mr_buf", 32'(u_if.dct_buffer),  32'd0);
        check_eq("mr_cnt", 32'(u_if.dct_count),   32'd0);
        check_eq("mr_ovf", 32'(overflow),         32'd0);
        check_eq("mr_drn", 32'(drained),          32'd0);
`ifdef FINAL2_SOC_DCT_DROP_CNT_EN
        check_eq("mr_drop", 32'(drop_cnt), 32'd0);
`endif
        reset_n = 1'b1;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("mr_flush_fv",  32'(u_if.frame_valid), 32'd0);
        check_eq("mr_flush_drn", 32'(drained),          32'd1);
        tick();
        check_eq("mr_flush_fv2", 32'(u_if.frame_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
